jstk_spi_master: RTL and testbench

//   SPI mode-0 master that runs a complete 5-byte PmodJSTK exchange from the 100MHz CLK:

---
 rtl/jstk_spi_master.sv | 194 +++++++++++++++++++
 tb/tb_jstk_spi_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_master.sv
// jstk_spi_master
//   SPI mode-0 master for a complete PmodJSTK poll. The SCLK is derived from
//   CLK by a half-period tick counter, so everything stays in one clock domain.
//   A poll is: SS low, a setup delay, NUM_BYTES bytes (MSB first) separated by
//   SCLK-low gaps with SS still low, then one FINISH cycle that publishes the
//   received frame on DOUT with a single-cycle DONE pulse.
// Ports
//   CLK    in   system clock, all state on the rising edge
//   RST    in   asynchronous active-high reset
//   sndRec in   start request, level-sampled only while idle
//   DIN    in   first byte sent; the remaining bytes send 8'h00
//   MISO   in   serial data from the slave, sampled as SCLK rises
//   SS     out  slave select, active-low
//   SCLK   out  serial clock, idles low
//   MOSI   out  serial data to the slave, MSB first
//   BUSY   out  high while a poll is in progress
//   DONE   out  one-cycle pulse when DOUT is updated
//   DOUT   out  received frame, first byte in the top 8 bits
module jstk_spi_master #(
  parameter int HALF_PERIOD = 375,
  parameter int NUM_BYTES   = 5,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sndRec,
  input  logic [7:0]             DIN,
  input  logic                   MISO,
  output logic                   SS,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [8*NUM_BYTES-1:0] DOUT
);

  localparam int FW = 8 * NUM_BYTES;
  localparam logic [15:0] HP_LAST    = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
  localparam logic [15:0] GAP_LAST   = 16'(BYTE_GAP - 1);
  localparam logic [2:0]  BYTE_LAST  = 3'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [7:0]      tx_q, tx_d;
  logic [FW-1:0]   rx_q, rx_d;
  logic [FW-1:0]   dout_q, dout_d;
  logic            ss_q, ss_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // End of a half period; with SCLK high this is a falling edge, and the
  // falling edge after bit 7 closes the byte.
  logic half_end;
  logic byte_end;
  assign half_end = (cnt_q == HP_LAST);
  assign byte_end = half_end && sclk_q && (bit_q == 3'd7);

  // State register and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sndRec) state_d = SETUP;
      SETUP:   if (cnt_q == SETUP_LAST) state_d = SHIFT;
      SHIFT:   if (byte_end) state_d = (byte_q == BYTE_LAST) ? FINISH : GAP;
      GAP:     if (cnt_q == GAP_LAST) state_d = SHIFT;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    dout_d = dout_q;
    ss_d   = ss_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sndRec) begin
          tx_d   = DIN;
          mosi_d = DIN[7];
          rx_d   = '0;
          bit_d  = '0;
          byte_d = '0;
          ss_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      SETUP: begin
        cnt_d = (cnt_q == SETUP_LAST) ? 16'd0 : cnt_q + 16'd1;
      end
      SHIFT: begin
        if (!half_end) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture MISO on the same CLK edge.
            sclk_d = 1'b1;
            rx_d   = {rx_q[FW-2:0], MISO};
          end else begin
            // Falling edge: present the next bit, or the next byte's MSB
            // (always 0, since only the first byte carries DIN).
            sclk_d = 1'b0;
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_d = byte_q + 3'd1;
              tx_d   = 8'h00;
              mosi_d = 1'b0;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end
          end
        end
      end
      GAP: begin
        cnt_d = (cnt_q == GAP_LAST) ? 16'd0 : cnt_q + 16'd1;
      end
      FINISH: begin
        cnt_d  = '0;
        dout_d = rx_q;
        done_d = 1'b1;
        ss_d   = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign SS   = ss_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_jstk_spi_master.sv
// Testbench for jstk_spi_master: one instance with default timing (index 0)
// and one with short timing (index 1). A slave model drives MISO from a
// 40-bit frame, and a monitor measures SCLK timing and collects MOSI bits.
module tb_jstk_spi_master;

  localparam int D_LAT = 1500 + 5 * 16 * 375 + 4 * 1000 + 1;  // 35501
  localparam int F_LAT = 3 + 5 * 32 + 4 * 2 + 1;              // 172

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  snd = 2'b00;
  logic [7:0]  din [2];
  logic [1:0]  miso = 2'b00;
  logic [1:0]  ss_w, sclk_w, mosi_w, busy_w, done_w;
  logic [39:0] dout [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  jstk_spi_master dut (
    .CLK(CLK), .RST(RST), .sndRec(snd[0]), .DIN(din[0]), .MISO(miso[0]),
    .SS(ss_w[0]), .SCLK(sclk_w[0]), .MOSI(mosi_w[0]), .BUSY(busy_w[0]),
    .DONE(done_w[0]), .DOUT(dout[0])
  );

  jstk_spi_master #(.HALF_PERIOD(2), .NUM_BYTES(5), .SS_SETUP(3), .BYTE_GAP(2)) dut_f (
    .CLK(CLK), .RST(RST), .sndRec(snd[1]), .DIN(din[1]), .MISO(miso[1]),
    .SS(ss_w[1]), .SCLK(sclk_w[1]), .MOSI(mosi_w[1]), .BUSY(busy_w[1]),
    .DONE(done_w[1]), .DOUT(dout[1])
  );

  // ---------------- slave model and bus monitor ----------------
  int          cyc = 0;
  int          hp_of  [2] = '{375, 2};
  int          gap_of [2] = '{1000, 2};
  logic [1:0]  prev_ss = 2'b11, prev_sclk = 2'b00, prev_done = 2'b00;
  int          rise_cnt [2] = '{0, 0};
  int          hi_bad   [2] = '{0, 0};
  int          lo_bad   [2] = '{0, 0};
  int          gap_cnt  [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          first_rise [2] = '{0, 0};
  int          ss_fall_cyc [2] = '{0, 0};
  int          last_rise [2] = '{0, 0};
  int          last_fall [2] = '{0, 0};
  int          frame_rises [2] = '{0, 0};
  int          bit_idx [2] = '{0, 0};
  logic [39:0] mosi_bits [2];
  logic [39:0] slave_frame [2];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      prev_ss[k]   <= ss_w[k];
      prev_sclk[k] <= sclk_w[k];
      prev_done[k] <= done_w[k];
      if (prev_ss[k] && !ss_w[k]) begin
        ss_fall_cyc[k] <= cyc;
        frame_rises[k] <= 0;
        bit_idx[k]     <= 0;
        miso[k]        <= slave_frame[k][39];
      end
      if (!prev_sclk[k] && sclk_w[k]) begin
        rise_cnt[k]    <= rise_cnt[k] + 1;
        frame_rises[k] <= frame_rises[k] + 1;
        mosi_bits[k]   <= {mosi_bits[k][38:0], mosi_w[k]};
        last_rise[k]   <= cyc;
        if (frame_rises[k] == 0) first_rise[k] <= cyc - ss_fall_cyc[k];
        else if (cyc - last_fall[k] == hp_of[k]) ;
        else if (cyc - last_fall[k] == hp_of[k] + gap_of[k]) gap_cnt[k] <= gap_cnt[k] + 1;
        else lo_bad[k] <= lo_bad[k] + 1;
      end
      if (prev_sclk[k] && !sclk_w[k]) begin
        last_fall[k] <= cyc;
        if (cyc - last_rise[k] != hp_of[k]) hi_bad[k] <= hi_bad[k] + 1;
        if (bit_idx[k] < 39) begin
          bit_idx[k] <= bit_idx[k] + 1;
          miso[k]    <= slave_frame[k][38 - bit_idx[k]];
        end
      end
      if (!prev_done[k] && done_w[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input int k, input logic [7:0] d);
    @(negedge CLK);
    din[k] = d;
    snd[k] = 1'b1;
    @(negedge CLK);
    snd[k] = 1'b0;
    din[k] = ~d;  // must not affect the frame in flight
  endtask

  task automatic wait_done(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done_w[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full poll on the short-timing instance, checked against the model.
  task automatic run_fast(input string tag, input logic [7:0] d, input logic [39:0] frame,
                          input logic [39:0] exp_dout, input logic [39:0] exp_mosi);
    int r0, h0, l0, g0;
    bit ok;
    r0 = rise_cnt[1]; h0 = hi_bad[1]; l0 = lo_bad[1]; g0 = gap_cnt[1];
    slave_frame[1] = frame;
    start(1, d);
    chk($sformatf("%s_busy", tag), busy_w[1], 1'b1);
    wait_done(1, 400, ok);
    chk($sformatf("%s_done_seen", tag), ok, 1'b1);
    chk($sformatf("%s_dout", tag), dout[1], exp_dout);
    chk($sformatf("%s_latency", tag), cyc - ss_fall_cyc[1], F_LAT);
    chk($sformatf("%s_mosi", tag), mosi_bits[1], exp_mosi);
    chk($sformatf("%s_rises", tag), rise_cnt[1] - r0, 40);
    chk($sformatf("%s_timing", tag), {hi_bad[1] - h0, lo_bad[1] - l0, gap_cnt[1] - g0}, {32'd0, 32'd0, 32'd4} );
    $display("txn %s: DIN=%02h DOUT=%010h latency=%0d", tag, d, dout[1], cyc - ss_fall_cyc[1]);
    @(negedge CLK);
    chk($sformatf("%s_done_pulse", tag), done_w[1], 1'b0);
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [39:0] frame;
    logic [39:0] exp_dout;
    logic [39:0] exp_mosi;
  } vec_t;

  initial begin
    vec_t        tbl [4];
    bit          ok;
    int          d0, r0, h0, l0, g0;
    logic [7:0]  q [$];
    logic [7:0]  rd;
    logic [39:0] fr, exp_mosi;

    tbl[0] = '{8'h83, 40'hA1B2C3D4E5, 40'hA1B2C3D4E5, 40'h8300000000};
    tbl[1] = '{8'hFF, 40'h0000000000, 40'h0000000000, 40'hFF00000000};
    tbl[2] = '{8'h00, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'h0000000000};
    tbl[3] = '{8'h5A, 40'h8001800180, 40'h8001800180, 40'h5A00000000};

    din[0] = 8'h00; din[1] = 8'h00;
    slave_frame[0] = '0; slave_frame[1] = '0;
    mosi_bits[0] = '0; mosi_bits[1] = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_outs%0d", k), {ss_w[k], sclk_w[k], mosi_w[k], busy_w[k], done_w[k]}, 5'b10000);
      chk($sformatf("rst_dout%0d", k), dout[k], 40'h0);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Full default-timing poll
    r0 = rise_cnt[0]; h0 = hi_bad[0]; l0 = lo_bad[0]; g0 = gap_cnt[0];
    slave_frame[0] = 40'hA1B2C3D4E5;
    start(0, 8'h83);
    chk("def_ss_low", ss_w[0], 1'b0);
    chk("def_busy", busy_w[0], 1'b1);
    wait_done(0, 40000, ok);
    chk("def_done_seen", ok, 1'b1);
    chk("def_dout", dout[0], 40'hA1B2C3D4E5);
    chk("def_latency", cyc - ss_fall_cyc[0], D_LAT);
    chk("def_end_ss_busy", {ss_w[0], busy_w[0]}, 2'b10);
    chk("def_rises", rise_cnt[0] - r0, 40);
    chk("def_mosi", mosi_bits[0], 40'h8300000000);
    chk("def_first_rise", first_rise[0], 1500 + 375);
    chk("def_hi_width_bad", hi_bad[0] - h0, 0);
    chk("def_lo_width_bad", lo_bad[0] - l0, 0);
    chk("def_gaps", gap_cnt[0] - g0, 4);
    $display("txn default: DIN=83 DOUT=%010h latency=%0d", dout[0], cyc - ss_fall_cyc[0]);
    @(negedge CLK);
    chk("def_done_pulse", done_w[0], 1'b0);
    repeat (20) @(negedge CLK);
    chk("def_dout_hold", dout[0], 40'hA1B2C3D4E5);
    chk("def_done_count", done_cnt[0], 1);

    // Reset mid-transaction while SCLK is high
    slave_frame[0] = 40'h123456789A;
    start(0, 8'h42);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (sclk_w[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_sclk_high_seen", ok, 1'b1);
    d0 = done_cnt[0];
    RST = 1'b1;
    #1;
    chk("mid_rst_outs", {ss_w[0], sclk_w[0], busy_w[0], done_w[0]}, 4'b1000);
    chk("mid_rst_dout", dout[0], 40'h0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (200) @(negedge CLK);
    chk("mid_no_done", done_cnt[0] - d0, 0);
    chk("mid_idle_ss", {ss_w[0], busy_w[0]}, 2'b10);
    $display("txn reset-abort: SS=%0b DOUT=%010h", ss_w[0], dout[0]);

    // Table vectors on the short-timing instance
    for (int i = 0; i < 4; i++)
      run_fast($sformatf("tbl%0d", i), tbl[i].din, tbl[i].frame, tbl[i].exp_dout, tbl[i].exp_mosi);

    // Random frames: slave bytes queue, first byte lands in the top of DOUT
    for (int i = 0; i < 8; i++) begin
      q.delete();
      for (int b = 0; b < 5; b++) q.push_back(8'($urandom_range(0, 255)));
      fr = '0;
      foreach (q[b]) fr = {fr[31:0], q[b]};
      rd = 8'($urandom_range(0, 255));
      exp_mosi = '0;
      for (int b = 0; b < 5; b++) exp_mosi = {exp_mosi[31:0], (b == 0) ? rd : 8'h00};
      run_fast($sformatf("rnd%0d", i), rd, fr, fr, exp_mosi);
    end

    // sndRec held high: back-to-back polls with one idle cycle of SS high
    d0 = done_cnt[1];
    slave_frame[1] = 40'h0F1E2D3C4B;
    @(negedge CLK);
    din[1] = 8'hC3;
    snd[1] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done(1, 400, ok);
      chk($sformatf("b2b%0d_done_seen", f), ok, 1'b1);
      chk($sformatf("b2b%0d_dout", f), dout[1], slave_frame[1]);
      chk($sformatf("b2b%0d_ss_high", f), ss_w[1], 1'b1);
      $display("txn b2b%0d: DOUT=%010h", f, dout[1]);
      slave_frame[1] = {$urandom, 8'($urandom_range(0, 255))};
      if (f == 2) snd[1] = 1'b0;
      @(negedge CLK);
      chk($sformatf("b2b%0d_ss_next", f), ss_w[1], (f == 2) ? 1'b1 : 1'b0);
    end
    repeat (5) @(negedge CLK);
    chk("b2b_done_count", done_cnt[1] - d0, 3);

    // sndRec pulsed while busy is ignored
    d0 = done_cnt[1];
    start(1, 8'h11);
    repeat (20) @(negedge CLK);
    snd[1] = 1'b1;
    @(negedge CLK);
    snd[1] = 1'b0;
    repeat (500) @(negedge CLK);
    chk("busy_pulse_one_done", done_cnt[1] - d0, 1);
    chk("busy_pulse_idle", {ss_w[1], busy_w[1]}, 2'b10);
    $display("txn busy-pulse: DOUT=%010h", dout[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
